// File: rtl/aes_pkg.sv
// Shared AES constants, FSM encoding and GF(2^8) helpers for the iterative MixColumns block.
package aes_pkg;

    localparam logic [7:0]  AES_RED  = 8'h1B;
    localparam int          STATE_W  = 128;
    localparam int          COL_W    = 32;
    localparam logic [31:0] FWD_COEF = 32'h02030101;
    localparam logic [31:0] INV_COEF = 32'h0e0b0d09;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } mc_state_t;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? AES_RED : 8'h00);
    endfunction

    // Every MixColumns coefficient fits in a nibble, so four xtime steps cover it.
    function automatic logic [7:0] gf_mul4(input logic [7:0] b, input logic [3:0] c);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = b;
        for (int i = 0; i < 4; i++) begin
            if (c[i]) begin
                acc = acc ^ p;
            end else begin
                acc = acc;
            end
            p = xtime(p);
        end
        return acc;
    endfunction

endpackage

// File: rtl/mix_column_core.sv
// Combinational single-column MixColumns / InvMixColumns transform.
module mix_column_core
    import aes_pkg::*;
#(
    parameter bit INV_EN = 1'b1
) (
    input  logic [COL_W-1:0] col,
    input  logic             inv,
    output logic [COL_W-1:0] result
);

    logic [31:0] coef_s;

    // Row r uses the coefficient row rotated right by r.
    always_comb begin
        coef_s = (INV_EN && inv) ? INV_COEF : FWD_COEF;
        result = 32'h0000_0000;
        for (int r = 0; r < 4; r++) begin
            for (int j = 0; j < 4; j++) begin
                result[31-8*r -: 8] = result[31-8*r -: 8]
                    ^ gf_mul4(col[31-8*j -: 8], coef_s[27-8*((j-r+4)%4) -: 4]);
            end
        end
    end

endmodule

// File: rtl/mix_columns_iter.sv
// Iterative AES MixColumns: captures a state, transforms COLS_PER_CYCLE columns per cycle, holds the result.
module mix_columns_iter
    import aes_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1,
    parameter bit INV_EN         = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_valid,
    output logic               o_ready,
    input  logic               i_inv,
    input  logic [STATE_W-1:0] i_state,
    output logic               o_valid,
    input  logic               i_ready,
    output logic [STATE_W-1:0] o_state
);

    localparam int         LAST_I   = 4 - COLS_PER_CYCLE;
    localparam logic [1:0] CNT_STEP = COLS_PER_CYCLE[1:0];
    localparam logic [1:0] CNT_LAST = LAST_I[1:0];

    mc_state_t          state_r, state_nxt_s;
    logic [1:0]         cnt_r;
    logic [STATE_W-1:0] data_r, data_nxt_s;
    logic               inv_r, valid_r, ready_r;
    logic [COL_W-1:0]   cols_s     [4];
    logic [COL_W-1:0]   cols_nxt_s [4];
    logic [COL_W-1:0]   col_in_s   [COLS_PER_CYCLE];
    logic [COL_W-1:0]   col_out_s  [COLS_PER_CYCLE];

    // Split the state register into columns and pick the ones due this cycle.
    always_comb begin
        for (int c = 0; c < 4; c++) begin
            cols_s[c] = data_r[127-32*c -: 32];
        end
        for (int k = 0; k < COLS_PER_CYCLE; k++) begin
            col_in_s[k] = cols_s[cnt_r + 2'(k)];
        end
    end

    for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_core
        mix_column_core #(.INV_EN(INV_EN)) u_core (
            .col    (col_in_s[g]),
            .inv    (inv_r),
            .result (col_out_s[g])
        );
    end

    // Write transformed columns back in place.
    always_comb begin
        cols_nxt_s = cols_s;
        for (int k = 0; k < COLS_PER_CYCLE; k++) begin
            cols_nxt_s[cnt_r + 2'(k)] = col_out_s[k];
        end
        data_nxt_s = '0;
        for (int c = 0; c < 4; c++) begin
            data_nxt_s[127-32*c -: 32] = cols_nxt_s[c];
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (i_valid) state_nxt_s = ST_BUSY;
                else         state_nxt_s = ST_IDLE;
            end
            ST_BUSY: begin
                if (cnt_r == CNT_LAST) state_nxt_s = ST_DONE;
                else                   state_nxt_s = ST_BUSY;
            end
            ST_DONE: begin
                if (i_ready) state_nxt_s = ST_IDLE;
                else         state_nxt_s = ST_DONE;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // FSM state register and handshake flags, decoded from the next state so outputs are flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            valid_r <= 1'b0;
            ready_r <= 1'b1;
        end else begin
            state_r <= state_nxt_s;
            valid_r <= (state_nxt_s == ST_DONE);
            ready_r <= (state_nxt_s == ST_IDLE);
        end
    end

    // State register, mode and column counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_r <= '0;
            cnt_r  <= 2'd0;
            inv_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (i_valid) begin
                        data_r <= i_state;
                        inv_r  <= INV_EN & i_inv;
                        cnt_r  <= 2'd0;
                    end
                end
                ST_BUSY: begin
                    data_r <= data_nxt_s;
                    cnt_r  <= cnt_r + CNT_STEP;
                end
                default: begin
                    data_r <= data_r;
                end
            endcase
        end
    end

    assign o_valid = valid_r;
    assign o_ready = ready_r;
    assign o_state = data_r;

endmodule

// File: tb/tb_mix_columns_iter.sv
// Self-checking bench for mix_columns_iter with 1, 2 and 4 columns per cycle builds.
module tb_mix_columns_iter;

    logic         clk = 1'b0;
    logic         rst;
    logic [2:0]   vld, inv, rdy, ovld, ordy;
    logic [127:0] st_in  [3];
    logic [127:0] st_out [3];

    int nvec  = 0;
    int nfail = 0;
    int lat_of [3] = '{4, 2, 1};

    always #5 clk = ~clk;

    mix_columns_iter #(.COLS_PER_CYCLE(1)) dut1 (
        .clk(clk), .rst(rst), .i_valid(vld[0]), .o_ready(ordy[0]), .i_inv(inv[0]),
        .i_state(st_in[0]), .o_valid(ovld[0]), .i_ready(rdy[0]), .o_state(st_out[0]));
    mix_columns_iter #(.COLS_PER_CYCLE(2)) dut2 (
        .clk(clk), .rst(rst), .i_valid(vld[1]), .o_ready(ordy[1]), .i_inv(inv[1]),
        .i_state(st_in[1]), .o_valid(ovld[1]), .i_ready(rdy[1]), .o_state(st_out[1]));
    mix_columns_iter #(.COLS_PER_CYCLE(4)) dut4 (
        .clk(clk), .rst(rst), .i_valid(vld[2]), .o_ready(ordy[2]), .i_inv(inv[2]),
        .i_state(st_in[2]), .o_valid(ovld[2]), .i_ready(rdy[2]), .o_state(st_out[2]));

    // Reference: textbook GF(2^8) multiply and the rotated coefficient matrix.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = 16'h0000;
        for (int i = 0; i < 8; i++)
            if (b[i]) p = p ^ ({8'h00, a} << i);
        for (int i = 14; i >= 8; i--)
            if (p[i]) p = p ^ (16'h011B << (i - 8));
        return p[7:0];
    endfunction

    function automatic logic [127:0] mix_ref(input logic [127:0] s, input logic m);
        logic [7:0]   base [4];
        logic [7:0]   acc;
        logic [127:0] o;
        if (m) base = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        else   base = '{8'h02, 8'h03, 8'h01, 8'h01};
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++)
                    acc = acc ^ gf_mul(s[127-32*c-8*j -: 8], base[(j-r+4)%4]);
                o[127-32*c-8*r -: 8] = acc;
            end
        return o;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One full transaction on DUT k; wiggle scrambles inputs while the block is busy.
    task automatic transact(input int k, input logic [127:0] s, input logic m,
                            input logic [127:0] exp, input int lat, input bit wiggle,
                            input string name);
        int n;
        n = 0;
        while (!ordy[k] && n < 50) begin @(posedge clk); #1; n++; end
        chk({name, " ready"}, 128'(ordy[k]), 128'd1);
        st_in[k] = s; inv[k] = m; vld[k] = 1'b1;
        @(posedge clk); #1;
        vld[k] = 1'b0; st_in[k] = rnd128();
        n = 0;
        while (!ovld[k] && n < 20) begin
            if (wiggle) begin
                inv[k] = ~inv[k]; vld[k] = 1'($urandom_range(0, 1)); st_in[k] = rnd128();
            end
            @(posedge clk); #1; n++;
        end
        vld[k] = 1'b0;
        chk({name, " latency"}, 128'(n), 128'(lat));
        chk({name, " state"}, st_out[k], exp);
        rdy[k] = 1'b1;
        @(posedge clk); #1;
        rdy[k] = 1'b0;
        chk({name, " valid drop"}, 128'(ovld[k]), 128'd0);
        chk({name, " ready back"}, 128'(ordy[k]), 128'd1);
    endtask

    typedef struct {
        logic [127:0] st;
        logic         m;
        logic [127:0] exp;
        int           dut;
    } vec_t;

    vec_t         tbl [6];
    logic [127:0] exp_q [$];
    logic [127:0] held, s, r;
    logic         acc, outp;
    int           sent, got, n;

    initial begin
        tbl[0] = '{st: 128'hdb135345_f20a225c_01010101_c6c6c6c6, m: 1'b0,
                   exp: 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, dut: 0};
        tbl[1] = '{st: 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, m: 1'b1,
                   exp: 128'hdb135345_f20a225c_01010101_c6c6c6c6, dut: 0};
        tbl[2] = '{st: 128'hd4d4d4d5_2d26314c_db135345_f20a225c, m: 1'b0,
                   exp: 128'hd5d5d7d6_4d7ebdf8_8e4da1bc_9fdc589d, dut: 2};
        tbl[3] = '{st: 128'hd4d4d4d5_2d26314c_db135345_f20a225c, m: 1'b0,
                   exp: 128'hd5d5d7d6_4d7ebdf8_8e4da1bc_9fdc589d, dut: 1};
        tbl[4] = '{st: 128'hd5d5d7d6_4d7ebdf8_8e4da1bc_9fdc589d, m: 1'b1,
                   exp: 128'hd4d4d4d5_2d26314c_db135345_f20a225c, dut: 2};
        tbl[5] = '{st: 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, m: 1'b1,
                   exp: 128'hdb135345_f20a225c_01010101_c6c6c6c6, dut: 1};

        rst = 1'b1; vld = 3'b000; inv = 3'b000; rdy = 3'b000;
        for (int k = 0; k < 3; k++) st_in[k] = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("reset valid d%0d", k), 128'(ovld[k]), 128'd0);
            chk($sformatf("reset ready d%0d", k), 128'(ordy[k]), 128'd1);
            chk($sformatf("reset state d%0d", k), st_out[k], 128'd0);
        end

        for (int i = 0; i < 6; i++)
            transact(tbl[i].dut, tbl[i].st, tbl[i].m, tbl[i].exp, lat_of[tbl[i].dut], 1'b0,
                     $sformatf("vec%0d", i));

        for (int k = 0; k < 3; k++)
            for (int i = 0; i < 3; i++) begin
                s = rnd128(); acc = 1'($urandom_range(0, 1));
                transact(k, s, acc, mix_ref(s, acc), lat_of[k], 1'b0, $sformatf("rnd d%0d.%0d", k, i));
            end

        // Inputs scrambled during BUSY must not disturb the captured mode or data.
        transact(0, tbl[0].st, 1'b0, tbl[0].exp, 4, 1'b1, "wiggle fwd");
        transact(0, tbl[1].st, 1'b1, tbl[1].exp, 4, 1'b1, "wiggle inv");

        // Backpressure: hold the result ten cycles while a new state is offered.
        st_in[0] = tbl[0].st; inv[0] = 1'b0; vld[0] = 1'b1;
        @(posedge clk); #1;
        st_in[0] = 128'h01010101_01010101_01010101_01010101;
        n = 0;
        while (!ovld[0] && n < 20) begin @(posedge clk); #1; n++; end
        chk("bp valid", 128'(ovld[0]), 128'd1);
        held = st_out[0];
        chk("bp result", held, tbl[0].exp);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk($sformatf("bp hold valid %0d", i), 128'(ovld[0]), 128'd1);
            chk($sformatf("bp hold state %0d", i), st_out[0], held);
            chk($sformatf("bp hold ready %0d", i), 128'(ordy[0]), 128'd0);
        end
        vld[0] = 1'b0; rdy[0] = 1'b1;
        @(posedge clk); #1;
        rdy[0] = 1'b0;
        repeat (6) @(posedge clk);
        #1 chk("bp no extra", 128'(ovld[0]), 128'd0);

        // Reset on the second BUSY edge aborts the operation.
        st_in[0] = tbl[0].st; inv[0] = 1'b0; vld[0] = 1'b1;
        @(posedge clk); #1;
        vld[0] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort valid", 128'(ovld[0]), 128'd0);
        chk("abort ready", 128'(ordy[0]), 128'd1);
        chk("abort state", st_out[0], 128'd0);
        repeat (6) begin
            @(posedge clk); #1;
            chk("abort no output", 128'(ovld[0]), 128'd0);
        end
        transact(0, {4{32'h01010101}}, 1'b0, {4{32'h01010101}}, 4, 1'b0, "after abort");

        // Back-to-back stream with random downstream stalls.
        sent = 0; got = 0; n = 0;
        s = rnd128(); inv[0] = 1'($urandom_range(0, 1)); st_in[0] = s; vld[0] = 1'b1;
        while (got < 8 && n < 2000) begin
            rdy[0] = 1'($urandom_range(0, 1));
            acc  = vld[0] & ordy[0];
            outp = ovld[0] & rdy[0];
            if (outp) begin
                if (exp_q.size() == 0) begin
                    chk("stream spurious", st_out[0], 128'hx);
                end else begin
                    r = exp_q.pop_front();
                    chk($sformatf("stream %0d", got), st_out[0], r);
                end
                got++;
            end
            if (acc) exp_q.push_back(mix_ref(st_in[0], inv[0]));
            @(posedge clk); #1;
            n++;
            if (acc) begin
                sent++;
                if (sent < 8) begin
                    s = rnd128(); st_in[0] = s; inv[0] = 1'($urandom_range(0, 1));
                end else begin
                    vld[0] = 1'b0;
                end
            end
        end
        rdy[0] = 1'b0;
        chk("stream count", 128'(got), 128'd8);
        chk("stream leftover", 128'(exp_q.size()), 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
